// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the register file between the in-order
// pipeline writeback and the multi-cycle execution unit (mul/div).
// Multi-cycle results are buffered in a small FIFO. The FIFO drains whenever
// the pipeline leaves the port idle. If the FIFO head has been denied
// STARVE_LIMIT cycles in a row, it is forced through and writeback stalls for
// that cycle.
//
// Handshakes:
//   wb : wb_valid is a request. wb_stall=1 means the request was not taken,
//        and the pipeline holds wb_* and retries. wb_stall=0 with wb_valid=1
//        means the request was consumed this cycle (written at this edge, or
//        dropped silently when wb_reg==0).
//   mc : strict valid/ready. A transfer happens on a rising edge where
//        mc_valid && mc_ready. mc_ready does not depend on mc_valid or on a
//        same-cycle dequeue. Results for r0 are accepted and discarded.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid/wb_reg/wb_data  pipeline writeback request
//   wb_stall                 writeback not accepted this cycle
//   mc_valid/mc_reg/mc_data  multi-cycle result
//   mc_ready                 multi-cycle result accepted this cycle
//   reg_write/write_reg/write_data  register file write port
//   pending_mask             bit i set iff a queued entry targets register i
//   fifo_count               current FIFO occupancy
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_valid,
  input  logic [ADDR_W-1:0]               wb_reg,
  input  logic [DATA_W-1:0]               wb_data,
  output logic                            wb_stall,
  input  logic                            mc_valid,
  output logic                            mc_ready,
  input  logic [ADDR_W-1:0]               mc_reg,
  input  logic [DATA_W-1:0]               mc_data,
  output logic                            reg_write,
  output logic [ADDR_W-1:0]               write_reg,
  output logic [DATA_W-1:0]               write_data,
  output logic [(1<<ADDR_W)-1:0]          pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 1 << ADDR_W;

  // FIFO storage; q_vld marks occupied slots so the pending mask can be
  // built directly from registered contents.
  logic [ADDR_W-1:0]     q_reg  [FIFO_DEPTH];
  logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [SC_W-1:0]       starve_cnt;

  logic fifo_nonempty;
  logic force_drain;
  logic wb_real;
  logic grant_wb;
  logic grant_fifo;
  logic enq;

  assign fifo_nonempty = (count != '0);
  assign force_drain   = fifo_nonempty && (starve_cnt == SC_W'(STARVE_LIMIT));
  // A writeback to r0 is never a real write; it leaves the port to the FIFO.
  assign wb_real       = wb_valid && (wb_reg != '0);
  assign grant_wb      = !rst && !force_drain && wb_real;
  assign grant_fifo    = !rst && fifo_nonempty && (force_drain || !wb_real);

  assign mc_ready      = !rst && (count < CNT_W'(FIFO_DEPTH));
  assign enq           = mc_valid && mc_ready && (mc_reg != '0);

  assign wb_stall      = !rst && force_drain && wb_valid;
  assign fifo_count    = count;

  // Write port mux; idle port drives zeros.
  always_comb begin
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    if (grant_fifo) begin
      reg_write  = 1'b1;
      write_reg  = q_reg[rd_ptr];
      write_data = q_data[rd_ptr];
    end else if (grant_wb) begin
      reg_write  = 1'b1;
      write_reg  = wb_reg;
      write_data = wb_data;
    end
  end

  // Duplicate destinations naturally keep a bit set until the last one drains.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_vld[i]) pending_mask[q_reg[i]] = 1'b1;
    end
  end

  // Payload storage needs no reset: q_vld qualifies every read that matters.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_reg[wr_ptr]  <= mc_reg;
      q_data[wr_ptr] <= mc_data;
    end
  end

  // Control state. Enqueue and dequeue never touch the same slot in one cycle:
  // enqueue needs a non-full FIFO, dequeue needs a non-empty one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      q_vld      <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (grant_fifo) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({enq, grant_fifo})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Count only the cycles an existing head is denied; a freshly filled
      // FIFO starts from zero.
      if (!fifo_nonempty || grant_fifo) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for regfile_write_arbiter. Every cycle's outputs are compared with a
// queue-based reference model of the write-port sharing rules.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 4;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_reg = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              wb_stall;
  logic              mc_valid = 1'b0;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_reg = '0;
  logic [DATA_W-1:0] mc_data = '0;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [15:0]       pending_mask;
  logic [1:0]        fifo_count;

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_reg(mc_reg), .mc_data(mc_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  // scoreboard: expected queue of buffered multi-cycle results
  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   denied = 0;        // cycles the current head has waited
  bit   model_known = 0;   // queue content is defined once one reset edge passed
  bit   last_stall = 0;
  bit   last_ready = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, check outputs against the model,
  // then advance the model across the rising edge
  task automatic step(input bit r,
                      input bit wv, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                      input bit mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md);
    bit                e_we, e_stall, e_ready, take_wb, take_head, forced;
    logic [ADDR_W-1:0] e_wr;
    logic [DATA_W-1:0] e_wd;
    logic [15:0]       e_mask;
    int                occ;
    @(negedge clk);
    rst = r; wb_valid = wv; wb_reg = wr; wb_data = wd;
    mc_valid = mv; mc_reg = mr; mc_data = md;
    #2;
    occ    = exp_q.size();
    e_mask = '0;
    foreach (exp_q[i]) e_mask = e_mask | (16'(1) << exp_q[i].r);
    e_we = 0; e_wr = '0; e_wd = '0; e_stall = 0; e_ready = 0;
    take_wb = 0; take_head = 0; forced = 0;
    if (!r) begin
      forced    = (occ > 0) && (denied >= STARVE_LIMIT);
      take_wb   = wv && (wr != 0) && !forced;
      take_head = (occ > 0) && !take_wb;
      e_stall   = wv && forced;
      e_ready   = occ < FIFO_DEPTH;
      if (take_head) begin
        e_we = 1; e_wr = exp_q[0].r; e_wd = exp_q[0].d;
      end else if (take_wb) begin
        e_we = 1; e_wr = wr; e_wd = wd;
      end
    end
    check("reg_write",  32'(reg_write),  32'(e_we));
    check("write_reg",  32'(write_reg),  32'(e_wr));
    check("write_data", 32'(write_data), 32'(e_wd));
    check("wb_stall",   32'(wb_stall),   32'(e_stall));
    check("mc_ready",   32'(mc_ready),   32'(e_ready));
    if (model_known) begin
      check("pending_mask", 32'(pending_mask), 32'(e_mask));
      check("fifo_count",   32'(fifo_count),   occ);
    end
    // model update for this edge
    if (r) begin
      exp_q.delete();
      denied      = 0;
      model_known = 1;
    end else begin
      if (occ == 0 || take_head) denied = 0;
      else if (denied < STARVE_LIMIT) denied++;
      if (take_head) void'(exp_q.pop_front());
      if (mv && e_ready && mr != 0) exp_q.push_back('{r: mr, d: md});
    end
    last_stall = e_stall;
    last_ready = e_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit                wv, mv, r;
    logic [ADDR_W-1:0] wr, mr;
    logic [DATA_W-1:0] wd, md;
    int                wb_pct, mc_pct;

    // reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd5, 16'h1111, 1, 4'd6, 16'h2222);

    // idle drain: r3 queued, written next cycle, then empty
    step(0, 0, 0, 0, 1, 4'd3, 16'h1234);
    idle(2);

    // priority: pipeline keeps the port for 3 cycles, head drains after
    step(0, 1, 4'd6, 16'h5555, 1, 4'd5, 16'hAAAA);
    step(0, 1, 4'd6, 16'h5555, 0, 0, 0);
    step(0, 1, 4'd6, 16'h5555, 0, 0, 0);
    step(0, 1, 4'd6, 16'h5555, 0, 0, 0);
    idle(2);

    // starvation: continuous writeback to r2 until the head is forced
    step(0, 1, 4'd2, 16'h0202, 1, 4'd7, 16'h0F0F);
    for (int i = 0; i < 7; i++) step(0, 1, 4'd2, 16'h0202, 0, 0, 0);
    idle(2);

    // full / backpressure, third result waits for space
    step(0, 1, 4'd1, 16'h0101, 1, 4'd8, 16'h8888);
    step(0, 1, 4'd1, 16'h0101, 1, 4'd9, 16'h9999);
    for (int i = 0; i < 3; i++) step(0, 1, 4'd1, 16'h0101, 1, 4'd10, 16'hA0A0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 4'd10, 16'hA0A0);
    step(0, 1, 4'd4, 16'h0404, 1, 4'd12, 16'hC0C0);
    idle(4);

    // r0 handling from both sources, plus duplicate destinations
    step(0, 1, 4'd0, 16'hDEAD, 1, 4'd0, 16'hBEEF);
    step(0, 1, 4'd0, 16'hDEAD, 1, 4'd0, 16'hBEEF);
    step(0, 1, 4'd3, 16'h0303, 1, 4'd13, 16'h1313);
    step(0, 1, 4'd3, 16'h0303, 1, 4'd13, 16'h2323);
    step(0, 1, 4'd0, 16'h0000, 0, 0, 0);
    idle(3);

    // reset mid-queue
    step(0, 1, 4'd1, 16'h0101, 1, 4'd11, 16'hB1B1);
    step(0, 1, 4'd1, 16'h0101, 1, 4'd12, 16'hC1C1);
    step(1, 1, 4'd1, 16'h0101, 1, 4'd14, 16'hE1E1);
    idle(4);

    // randomized traffic at several densities
    wv = 0; wr = '0; wd = '0; mv = 0; mr = '0; md = '0;
    for (int ph = 0; ph < 4; ph++) begin
      wb_pct = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 60 : 100;
      mc_pct = (ph == 0) ? 50 : (ph == 1) ? 70 : (ph == 2) ? 90 : 40;
      for (int c = 0; c < 400; c++) begin
        // pipeline holds its request while stalled
        if (!(last_stall && wv)) begin
          wv = ($urandom_range(99) < wb_pct);
          wr = ADDR_W'($urandom_range((1 << ADDR_W) - 1));
          wd = DATA_W'($urandom);
        end
        // valid/ready: an offered result holds until accepted
        if (!(mv && !last_ready)) begin
          mv = ($urandom_range(99) < mc_pct);
          mr = ADDR_W'($urandom_range((1 << ADDR_W) - 1));
          md = DATA_W'($urandom);
        end
        r = ($urandom_range(199) == 0);
        step(r, wv, wr, wd, mv, mr, md);
        if (r) begin
          wv = 0; mv = 0;
        end
      end
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16x16 register file between two sources: the in-order pipeline writeback and the multi-cycle execution unit (mul/div).
- Multi-cycle results are buffered in a small FIFO and drain whenever the pipeline leaves the port idle.
- A starvation counter forces a drain, and stalls writeback for that cycle, if the FIFO head waits too long.
- Exports a pending-register mask so the issue stage can interlock on queued destinations.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register index width (2**ADDR_W registers)
FIFO_DEPTH, 2, multi-cycle result buffer entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive denied cycles before FIFO head is forced through (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wb_valid  in  1  pipeline writeback request this cycle
wb_reg  in  ADDR_W  pipeline destination register
wb_data  in  DATA_W  pipeline write data
wb_stall  out  1  pipeline writeback not accepted this cycle; pipeline holds wb_* and retries
mc_valid  in  1  multi-cycle unit result valid
mc_ready  out  1  arbiter accepts multi-cycle result this cycle
mc_reg  in  ADDR_W  multi-cycle destination register
mc_data  in  DATA_W  multi-cycle result data
reg_write  out  1  register file write enable
write_reg  out  ADDR_W  register file write index
write_data  out  DATA_W  register file write data
pending_mask  out  2**ADDR_W  bit i set iff a FIFO entry targets register i
fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: FIFO empty, fifo_count=0, starve_cnt=0, pending_mask=0. While rst is high, reg_write=0, wb_stall=0, mc_ready=0.
- Grant logic (combinational from registered state and current inputs):
  - force = (fifo_count!=0) && (starve_cnt==STARVE_LIMIT).
  - If force: grant FIFO head; wb_stall=wb_valid.
  - Else if wb_valid and wb_reg!=0: grant pipeline; wb_stall=0.
  - Else if fifo_count!=0: grant FIFO head.
  - Else: no write.
- reg_write=1 only for a granted request. write_reg/write_data come from the granted source; they are 0 when reg_write=0.
- Writeback latency: zero. A granted wb request is written at the same clock edge.
- Register 0: a wb request with wb_reg==0 is consumed silently (wb_stall=0 unless force). An mc handshake with mc_reg==0 is accepted but not enqueued. r0 never appears on write_reg.
- mc handshake: mc_ready = (fifo_count<FIFO_DEPTH) && !rst. Transfer occurs when mc_valid && mc_ready. Entries are written at the tail on that edge.
- Enqueue and dequeue in the same cycle are allowed; count is unchanged. A full FIFO does not accept in the cycle it drains (mc_ready is not a function of the dequeue).
- FIFO order: strict FIFO. The head drains at most one entry per cycle.
- starve_cnt:
  - Cleared when the FIFO is empty or the head is granted.
  - Incremented when the FIFO is non-empty and the head is not granted.
  - Saturates at STARVE_LIMIT.
  - A newly enqueued entry into an empty FIFO starts at 0 on the next cycle.
- pending_mask is derived only from registered FIFO contents. A bit sets the cycle after enqueue and clears the cycle after its entry is written. A duplicate destination across entries keeps the bit set until the last such entry drains.
- No reordering or hazard checking between sources; the issue stage uses pending_mask to avoid WAW/RAW on queued destinations.
- Reset mid-operation: all queued entries are discarded, and no write occurs in the reset cycle.

Test Plan:
- Idle drain: rst released, mc pushes r3=0x1234 at cycle 0 with wb idle -> pending_mask=0x0008 at cycle 1; reg_write=1, write_reg=3, write_data=0x1234 at cycle 1; pending_mask=0 and fifo_count=0 at cycle 2.
- Priority: FIFO holds r5=0xAAAA, wb_valid with r6=0x5555 for 3 cycles then idle -> writes r6 three times with no stall, then r5 on cycle 4; starve_cnt reaches 3, no force.
- Starvation: FIFO holds r7=0x0F0F, wb_valid continuous to r2 -> after 4 denied cycles, cycle 5 writes r7 with wb_stall=1 and the wb hold respected; cycle 6 writes r2 with wb_stall=0.
- Full/backpressure (DEPTH=2): two mc pushes under continuous wb traffic -> fifo_count=2, mc_ready=0; a third mc_valid holds until count drops to 1. Simultaneous push/pop keeps count=1.
- r0 handling: wb_reg=0 and mc_reg=0 requests -> never reg_write to r0, no FIFO entry, mc_ready handshake completes, pending_mask bit0 stays 0.
- Reset mid-queue: FIFO holds 2 entries, assert rst for 1 cycle -> reg_write=0 in that cycle, then fifo_count=0, pending_mask=0, and no queued writes ever appear.
